// File: rtl/hook_draw_scheduler.sv
// Per-frame sequencer sharing one framebuffer write port between two hook renderers.
// Runs hook 1 then (optionally) hook 2, with a per-stage watchdog.
module hook_draw_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CW             = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        p2_active,
  output logic        h1_enable,
  input  logic [8:0]  h1_x,
  input  logic [7:0]  h1_y,
  input  logic [11:0] h1_color,
  input  logic        h1_we,
  input  logic        h1_done,
  output logic        h2_enable,
  input  logic [8:0]  h2_x,
  input  logic [7:0]  h2_y,
  input  logic [11:0] h2_color,
  input  logic        h2_we,
  input  logic        h2_done,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [11:0] vga_color,
  output logic        vga_we,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START1,
    S_WAIT1,
    S_START2,
    S_WAIT2,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic          p2_latched_q, p2_latched_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic          h1_en_q, h1_en_d;
  logic          h2_en_q, h2_en_d;
  logic          fdone_q, fdone_d;
  logic [8:0]    vx_q, vx_d;
  logic [7:0]    vy_q, vy_d;
  logic [11:0]   vc_q, vc_d;
  logic          vwe_q, vwe_d;

  // Next-state, watchdog, handshake pulses and pixel mux
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    p2_latched_d = p2_latched_q;
    wd_d         = wd_q;
    busy_d       = busy_q;
    terr_d       = terr_q;
    h1_en_d      = 1'b0;
    h2_en_d      = 1'b0;
    fdone_d      = 1'b0;
    vx_d         = vx_q;
    vy_d         = vy_q;
    vc_d         = vc_q;
    vwe_d        = 1'b0;

    // ticks arriving mid-frame collapse into a single queued frame
    if (frame_start && (state_q != S_IDLE))
      pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start || pending_q) begin
          state_d      = S_START1;
          p2_latched_d = p2_active;
          pending_d    = 1'b0;
          busy_d       = 1'b1;
          h1_en_d      = 1'b1;
        end
      end

      S_START1: begin
        wd_d    = '0;
        state_d = S_WAIT1;
      end

      S_WAIT1: begin
        vx_d  = h1_x;
        vy_d  = h1_y;
        vc_d  = h1_color;
        vwe_d = h1_we;
        if (h1_done || (wd_q == WD_MAX)) begin
          if (!h1_done)
            terr_d = 1'b1;
          if (p2_latched_q) begin
            state_d = S_START2;
            h2_en_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_START2: begin
        wd_d    = '0;
        state_d = S_WAIT2;
      end

      S_WAIT2: begin
        vx_d  = h2_x;
        vy_d  = h2_y;
        vc_d  = h2_color;
        vwe_d = h2_we;
        if (h2_done || (wd_q == WD_MAX)) begin
          if (!h2_done)
            terr_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_DONE: begin
        fdone_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      p2_latched_q <= 1'b0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      h1_en_q      <= 1'b0;
      h2_en_q      <= 1'b0;
      fdone_q      <= 1'b0;
      vx_q         <= '0;
      vy_q         <= '0;
      vc_q         <= '0;
      vwe_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      p2_latched_q <= p2_latched_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
      h1_en_q      <= h1_en_d;
      h2_en_q      <= h2_en_d;
      fdone_q      <= fdone_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      vc_q         <= vc_d;
      vwe_q        <= vwe_d;
    end
  end

  assign h1_enable   = h1_en_q;
  assign h2_enable   = h2_en_q;
  assign vga_x       = vx_q;
  assign vga_y       = vy_q;
  assign vga_color   = vc_q;
  assign vga_we      = vwe_q;
  assign busy        = busy_q;
  assign frame_done  = fdone_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_hook_draw_scheduler.sv
// Bench for hook_draw_scheduler: scoreboarded pixel path plus
// frame sequencing, overrun, watchdog and mid-frame reset scenarios.
module tb_hook_draw_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        p2_active = 1'b0;
  logic [8:0]  h1_x = '0, h2_x = '0;
  logic [7:0]  h1_y = '0, h2_y = '0;
  logic [11:0] h1_color = '0, h2_color = '0;
  logic        h1_we = 1'b0, h2_we = 1'b0;
  logic        h1_done = 1'b0, h2_done = 1'b0;

  logic        h1_enable, h2_enable;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [11:0] vga_color;
  logic        vga_we, busy, frame_done, timeout_err;

  logic        w_h1_enable, w_h2_enable;
  logic [8:0]  w_vga_x;
  logic [7:0]  w_vga_y;
  logic [11:0] w_vga_color;
  logic        w_vga_we, w_busy, w_frame_done, w_timeout_err;

  hook_draw_scheduler dut (
    .clock(clock), .reset(reset),
    .frame_start(frame_start), .p2_active(p2_active),
    .h1_enable(h1_enable), .h1_x(h1_x), .h1_y(h1_y),
    .h1_color(h1_color), .h1_we(h1_we), .h1_done(h1_done),
    .h2_enable(h2_enable), .h2_x(h2_x), .h2_y(h2_y),
    .h2_color(h2_color), .h2_we(h2_we), .h2_done(h2_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_we(vga_we), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  hook_draw_scheduler #(.TIMEOUT_CYCLES(16), .CW(5)) dut_wd (
    .clock(clock), .reset(reset),
    .frame_start(frame_start), .p2_active(p2_active),
    .h1_enable(w_h1_enable), .h1_x(h1_x), .h1_y(h1_y),
    .h1_color(h1_color), .h1_we(h1_we), .h1_done(h1_done),
    .h2_enable(w_h2_enable), .h2_x(h2_x), .h2_y(h2_y),
    .h2_color(h2_color), .h2_we(h2_we), .h2_done(h2_done),
    .vga_x(w_vga_x), .vga_y(w_vga_y), .vga_color(w_vga_color),
    .vga_we(w_vga_we), .busy(w_busy), .frame_done(w_frame_done),
    .timeout_err(w_timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int errs = 0;
  int checks = 0;
  int n_h1 = 0, n_h2 = 0, n_fd = 0;
  logic [28:0] pix_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Monitor on the main instance: pixel scoreboard and pulse exclusivity
  always @(negedge clock) begin
    if (vga_we) begin
      if (pix_q.size() == 0) begin
        check("pix_unexpected", 32'(vga_we), 32'd0);
      end else begin
        logic [28:0] e;
        e = pix_q.pop_front();
        check("pix", 32'({vga_x, vga_y, vga_color}), 32'(e));
      end
    end
    if (h1_enable || h2_enable || frame_done)
      check("pulse_excl",
            32'((h1_enable & h2_enable) |
                (frame_done & (h1_enable | h2_enable))), 32'd0);
    if (h1_enable) n_h1++;
    if (h2_enable) n_h2++;
    if (frame_done) n_fd++;
  end

  int e, h1c, nbase;

  initial begin
    // reset for two cycles
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vwe", 32'(vga_we), 32'd0);
    check("rst_vpix", 32'({vga_x, vga_y, vga_color}), 32'd0);
    check("rst_en", 32'({h1_enable, h2_enable}), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // basic two-player frame, tick at cycle 10
    while (cyc < 10) step();
    check("h1_en_pre", 32'(h1_enable), 32'd0);
    frame_start = 1'b1;
    p2_active   = 1'b1;
    step();
    frame_start = 1'b0;
    check("h1_en_c11", 32'(h1_enable), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    step();

    // hook 1 pixel stream with hook 2 strobing alongside
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin
        h1_x = 9'd100; h1_y = 8'd60; h1_color = 12'hBBB; h1_we = 1'b1;
      end else begin
        h1_x = 9'($urandom); h1_y = 8'($urandom);
        h1_color = 12'($urandom); h1_we = 1'($urandom);
      end
      h2_x = ~h1_x; h2_y = ~h1_y; h2_color = ~h1_color; h2_we = 1'b1;
      if (h1_we) pix_q.push_back({h1_x, h1_y, h1_color});
      step();
    end
    h1_we = 1'b0;
    h2_we = 1'b0;
    step();
    check("pix_drain1", 32'(pix_q.size()), 32'd0);

    // hook 1 done 300 cycles after its enable
    while (cyc < 311) step();
    h1_done = 1'b1;
    step();
    h1_done = 1'b0;
    check("h2_en", 32'(h2_enable), 32'd1);
    step();

    // hook 2 stream, hook 1 junk, three overrun ticks
    for (int i = 0; i < 20; i++) begin
      h2_x = 9'($urandom); h2_y = 8'($urandom);
      h2_color = 12'($urandom); h2_we = 1'($urandom);
      h1_x = ~h2_x; h1_y = ~h2_y; h1_color = ~h2_color; h1_we = 1'b1;
      frame_start = (i == 7) || (i == 12) || (i == 17);
      if (h2_we) pix_q.push_back({h2_x, h2_y, h2_color});
      step();
    end
    frame_start = 1'b0;
    h1_we = 1'b0;
    h2_we = 1'b0;
    step();
    check("pix_drain2", 32'(pix_q.size()), 32'd0);

    // hook 2 done 320 cycles after its enable
    while (cyc < 632) step();
    h2_done = 1'b1;
    step();
    h2_done = 1'b0;
    p2_active = 1'b0;
    check("fd_early", 32'(frame_done), 32'd0);
    step();
    check("fd_pulse", 32'(frame_done), 32'd1);
    check("busy_off", 32'(busy), 32'd0);
    check("terr_clean", 32'(timeout_err), 32'd0);
    step();
    check("fd_single", 32'(frame_done), 32'd0);
    check("overrun_en", 32'(h1_enable), 32'd1);

    // overrun frame runs single-player
    while (cyc < 685) step();
    h1_done = 1'b1;
    step();
    h1_done = 1'b0;
    check("sp_h2_off", 32'(h2_enable), 32'd0);
    check("sp_fd_early", 32'(frame_done), 32'd0);
    step();
    check("sp_fd", 32'(frame_done), 32'd1);
    for (int i = 0; i < 40; i++) step();
    check("n_h1", 32'(n_h1), 32'd2);
    check("n_h2", 32'(n_h2), 32'd1);
    check("n_fd", 32'(n_fd), 32'd2);

    // watchdog on the 16-cycle instance
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("wd_rst", 32'(w_timeout_err), 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    e = cyc;
    check("wd_en", 32'(w_h1_enable), 32'd1);
    while (cyc < e + 16) step();
    check("wd_terr_pre", 32'(w_timeout_err), 32'd0);
    check("wd_fd_pre", 32'(w_frame_done), 32'd0);
    step();
    check("wd_terr", 32'(w_timeout_err), 32'd1);
    step();
    check("wd_fd", 32'(w_frame_done), 32'd1);

    // clean frame keeps the sticky error
    for (int i = 0; i < 3; i++) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    e = cyc;
    check("wd2_en", 32'(w_h1_enable), 32'd1);
    while (cyc < e + 5) step();
    h1_done = 1'b1;
    step();
    h1_done = 1'b0;
    step();
    check("wd2_fd", 32'(w_frame_done), 32'd1);
    check("wd_sticky", 32'(w_timeout_err), 32'd1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("wd_clr", 32'(w_timeout_err), 32'd0);

    // done on the last watchdog cycle wins over timeout
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    e = cyc;
    while (cyc < e + 16) step();
    h1_done = 1'b1;
    step();
    h1_done = 1'b0;
    check("wd_prio_terr", 32'(w_timeout_err), 32'd0);
    step();
    check("wd_prio_fd", 32'(w_frame_done), 32'd1);

    // reset in the middle of hook 1 with a queued tick
    reset = 1'b1;
    step();
    reset = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    nbase = n_h1;
    h1_we = 1'b1;
    h1_x = 9'd7;
    reset = 1'b1;
    step();
    reset = 1'b0;
    h1_we = 1'b0;
    check("mr_vwe", 32'(vga_we), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_state", 32'(dut.state_q), 32'd0);
    check("mr_pending", 32'(dut.pending_q), 32'd0);
    for (int i = 0; i < 20; i++) step();
    h1c = n_h1;
    check("mr_no_reissue", 32'(h1c), 32'(nbase));
    check("pix_drain3", 32'(pix_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
